// File: rtl/core_instr_fifo_if.sv
// Push/pop/lookup bundle between the arbiter, one core and its instruction FIFO.
// master: arbiter/core side; slave: FIFO side.
interface core_instr_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic [11:0]       q_key;
  logic              q_hit;

  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
    output q_key,
    input  full,
    input  rd_data,
    input  empty,
    input  count,
    input  overflow,
    input  underflow,
    input  q_hit
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    input  q_key,
    output full,
    output rd_data,
    output empty,
    output count,
    output overflow,
    output underflow,
    output q_hit
  );
endinterface

// File: rtl/core_instr_fifo.sv
// Per-core FWFT instruction queue with an operand-key lookup port.
// Ports: clk, reset (sync, active-high), bus (slave: push/pop/status/lookup).
module core_instr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  core_instr_fifo_if.slave   bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic              unf;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (cnt == (ADDR_W+1)'(DEPTH));
  assign empty = (cnt == '0);
  // Both qualified on pre-edge state: no bypass in either direction.
  assign push  = bus.wr_en & ~full;
  assign pop   = bus.rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (ADDR_W+1)'(push)
                 - (ADDR_W+1)'(pop);
      if (bus.wr_en & full)
        ovf <= 1'b1;
      if (bus.rd_en & empty)
        unf <= 1'b1;
    end
  end

  // Storage is never cleared; validity comes from cnt/rd_ptr only.
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= bus.wr_data;
  end

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [ADDR_W-1:0] off;
    logic [11:0]       src_key;
    logic [11:0]       dst_key;
    // Distance from head, modulo DEPTH; entry is live if within cnt.
    assign off       = ADDR_W'(g) - rd_ptr;
    assign valid[g]  = ({1'b0, off} < cnt);
    assign src_key   = {mem[g][23], mem[g][10:0]};
    assign dst_key   = {mem[g][22], mem[g][21:11]};
    assign match[g]  = (src_key == bus.q_key)
                     | (dst_key == bus.q_key);
  end

  assign bus.q_hit     = |(valid & match);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
  assign bus.rd_data   = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_core_instr_fifo.sv
// Self-checking bench for core_instr_fifo: vector table, directed
// sequences and randomized traffic against a queue-based model.
module tb_core_instr_fifo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_instr_fifo_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  core_instr_fifo #(.DATA_W(32), .DEPTH(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  bit          mov;
  bit          mun;

  typedef struct {
    bit          rst;
    bit          wr;
    bit          rd;
    logic [31:0] wd;
    logic [11:0] qk;
    int          cnt;
    logic [31:0] rdd;
    bit          ov;
    bit          un;
    bit          hit;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit mhit(logic [11:0] k);
    foreach (mq[i]) begin
      if ({mq[i][23], mq[i][10:0]} == k) return 1'b1;
      if ({mq[i][22], mq[i][21:11]} == k) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cyc(bit rst, bit wr, bit rd, logic [31:0] wd);
    bit mf;
    bit me;
    reset       = rst;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.wr_data = wd;
    @(posedge clk);
    mf = (mq.size() == 8);
    me = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      mov = 1'b0;
      mun = 1'b0;
    end else begin
      if (wr && mf) mov = 1'b1;
      if (rd && me) mun = 1'b1;
      if (rd && !me) void'(mq.pop_front());
      if (wr && !mf) mq.push_back(wd);
    end
    #1;
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic check_all(string tag);
    logic [31:0] erd;
    erd = (mq.size() == 0) ? 32'h0 : mq[0];
    chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
    chk({tag, ".rd_data"}, bus.rd_data, erd);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(mq.size() == 8));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(mov));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(mun));
    chk({tag, ".q_hit"}, 32'(bus.q_hit), 32'(mhit(bus.q_key)));
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    bus.q_key   = '0;

    // rst wr rd wdata qkey | cnt rd_data ov un hit
    tbl[0] = '{1, 0, 0, 32'h0, 12'h000, 0, 32'h0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 32'h00A0_1003, 12'h803,
               1, 32'h00A0_1003, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 32'h0, 12'h803, 0, 32'h0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 32'h55, 12'h055, 1, 32'h55, 0, 1, 1};
    tbl[4] = '{1, 1, 0, 32'h77, 12'h055, 0, 32'h0, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 32'h0040_0805, 12'h801,
               1, 32'h0040_0805, 0, 0, 1};
    tbl[6] = '{0, 0, 0, 32'h0, 12'h005, 1, 32'h0040_0805, 0, 0, 1};
    tbl[7] = '{0, 0, 0, 32'h0, 12'h006, 1, 32'h0040_0805, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 32'h0, 12'h001, 1, 32'h0040_0805, 0, 0, 0};
    tbl[9] = '{0, 0, 1, 32'h0, 12'h801, 0, 32'h0, 0, 0, 0};

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      bus.q_key = tbl[i].qk;
      cyc(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      chk({t, ".count"}, 32'(bus.count), 32'(tbl[i].cnt));
      chk({t, ".rd_data"}, bus.rd_data, tbl[i].rdd);
      chk({t, ".empty"}, 32'(bus.empty), 32'(tbl[i].cnt == 0));
      chk({t, ".full"}, 32'(bus.full), 32'(tbl[i].cnt == 8));
      chk({t, ".overflow"}, 32'(bus.overflow), 32'(tbl[i].ov));
      chk({t, ".underflow"}, 32'(bus.underflow), 32'(tbl[i].un));
      chk({t, ".q_hit"}, 32'(bus.q_hit), 32'(tbl[i].hit));
    end

    // Fill to full, overflow, drain in order.
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 32'(i));
    chk("fill.full", 32'(bus.full), 1);
    chk("fill.count", 32'(bus.count), 8);
    cyc(0, 1, 0, 32'h9);
    chk("ovf.flag", 32'(bus.overflow), 1);
    chk("ovf.count", 32'(bus.count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.data", bus.rd_data, 32'(i));
      cyc(0, 0, 1, 0);
    end
    chk("drain.empty", 32'(bus.empty), 1);
    chk("drain.rd_data", bus.rd_data, 0);
    chk("drain.overflow", 32'(bus.overflow), 1);

    // Full + push + pop: pop done, push rejected.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 32'h100 + 32'(i));
    cyc(0, 1, 1, 32'hDEAD);
    check_all("fullrw");
    chk("fullrw.count", 32'(bus.count), 7);
    chk("fullrw.head", bus.rd_data, 32'h101);

    // Steady push+pop at count 3 across pointer wrap.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h200 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      chk("steady.head", bus.rd_data, 32'h200 + 32'(i));
      cyc(0, 1, 1, 32'h203 + 32'(i));
      chk("steady.count", 32'(bus.count), 3);
    end
    check_all("steady");

    // Reset with concurrent push discards everything.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'h0000_0004 + 32'(i));
    bus.q_key = 12'h004;
    #1;
    chk("prerst.q_hit", 32'(bus.q_hit), 1);
    cyc(1, 1, 0, 32'h0000_0004);
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.empty", 32'(bus.empty), 1);
    chk("rst.q_hit", 32'(bus.q_hit), 0);
    check_all("rst");

    // Random traffic with a narrow key space to make hits frequent.
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit w;
      bit d;
      logic [31:0] wd;
      r  = ($urandom_range(0, 49) == 0);
      w  = ($urandom_range(0, 99) < 55);
      d  = ($urandom_range(0, 99) < 50);
      wd = $urandom & 32'hFFC0_3807;
      bus.q_key = {1'($urandom_range(0, 1)), 8'h00,
                   3'($urandom_range(0, 7))};
      cyc(r, w, d, wd);
      check_all("rand");
      bus.q_key = {1'($urandom_range(0, 1)), 8'h00,
                   3'($urandom_range(0, 7))};
      #1;
      chk("rand.q_hit2", 32'(bus.q_hit), 32'(mhit(bus.q_key)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
